// File: rtl/seven_seg_scan_driver_pkg.sv
// seven_seg_scan_driver_pkg
//   Shared glyph constants for the 7-segment scan driver.
//   Segment bit order (active low): {dp,g,f,e,d,c,b,a}, bit 7 = dp.
//   Every GLYPH_* constant has the dp bit at 1 (dp off); the driver ORs the dp in separately.
package seven_seg_scan_driver_pkg;

    localparam logic [7:0] GLYPH_0   = 8'hC0;
    localparam logic [7:0] GLYPH_1   = 8'hF9;
    localparam logic [7:0] GLYPH_2   = 8'hA4;
    localparam logic [7:0] GLYPH_3   = 8'hB0;
    localparam logic [7:0] GLYPH_4   = 8'h99;
    localparam logic [7:0] GLYPH_5   = 8'h92;
    localparam logic [7:0] GLYPH_6   = 8'h82;
    localparam logic [7:0] GLYPH_7   = 8'hD8;
    localparam logic [7:0] GLYPH_8   = 8'h80;
    localparam logic [7:0] GLYPH_9   = 8'h90;
    localparam logic [7:0] GLYPH_A   = 8'h88;
    localparam logic [7:0] GLYPH_B   = 8'h83;
    localparam logic [7:0] GLYPH_C   = 8'hC6;
    localparam logic [7:0] GLYPH_D   = 8'hA1;
    localparam logic [7:0] GLYPH_E   = 8'h86;
    localparam logic [7:0] GLYPH_F   = 8'h8E;
    localparam logic [7:0] GLYPH_OFF = 8'hFF;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if
//   Data/display bundle of the scan driver.
//   master: the data source (drives bcd_in, dp_in, load, blank_en; observes display outputs).
//   slave : the scan driver itself.
//   bcd_in[3:0] is digit 0 (least significant). seg_out/digit_en are active low.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_en;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [IDX_W-1:0]        scan_idx;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, load, blank_en,
        input  seg_out, digit_en, scan_idx, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_en,
        output seg_out, digit_en, scan_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver_glyph.sv
// seven_seg_scan_driver_glyph
//   Combinational 4-bit code -> 7-bit glyph {g,f,e,d,c,b,a}, active low.
//   Ports: code (in, 4), glyph (out, 7).
//   Config macro HEX_DIGITS_EN: when defined, codes A-F render hex letters;
//   otherwise they render all segments off.
module seven_seg_scan_driver_glyph
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = GLYPH_OFF[6:0];
        case (code)
            4'h0: glyph = GLYPH_0[6:0];
            4'h1: glyph = GLYPH_1[6:0];
            4'h2: glyph = GLYPH_2[6:0];
            4'h3: glyph = GLYPH_3[6:0];
            4'h4: glyph = GLYPH_4[6:0];
            4'h5: glyph = GLYPH_5[6:0];
            4'h6: glyph = GLYPH_6[6:0];
            4'h7: glyph = GLYPH_7[6:0];
            4'h8: glyph = GLYPH_8[6:0];
            4'h9: glyph = GLYPH_9[6:0];
`ifdef HEX_DIGITS_EN
            4'hA: glyph = GLYPH_A[6:0];
            4'hB: glyph = GLYPH_B[6:0];
            4'hC: glyph = GLYPH_C[6:0];
            4'hD: glyph = GLYPH_D[6:0];
            4'hE: glyph = GLYPH_E[6:0];
            4'hF: glyph = GLYPH_F[6:0];
`else
            default: glyph = GLYPH_OFF[6:0];
`endif
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Multiplexed N-digit common-anode 7-segment scan driver with double-buffered
//   data, leading-zero blanking and an inter-digit ghosting guard.
//   Ports: clk, reset (async, active high), bus (seven_seg_scan_driver_if.slave):
//     bcd_in/dp_in/load  -> pending register; copied to display on frame wrap
//     blank_en           -> live leading-zero suppression
//     seg_out/digit_en   -> registered, active low; lag scan_idx by one clk
//     scan_idx           -> digit being scanned; frame_done pulses on wrap to 0
//   Config macro HEX_DIGITS_EN (handled in the glyph sub-module).
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    seven_seg_scan_driver_if.slave     bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]            cnt;
    logic                        tick;
    logic                        wrap;
    logic [NUM_DIGITS-1:0][3:0]  pend_bcd;
    logic [NUM_DIGITS-1:0][3:0]  disp_bcd;
    logic [NUM_DIGITS-1:0]       pend_dp;
    logic [NUM_DIGITS-1:0]       disp_dp;
    logic [NUM_DIGITS-1:0][6:0]  glyph;
    logic [NUM_DIGITS-1:0][7:0]  seg_d;
    logic [NUM_DIGITS:0]         zero_above;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));
    assign wrap = tick && (bus.scan_idx == IDX_W'(NUM_DIGITS - 1));

    // zero_above[i]: display digits i..N-1 are all zero (leading-zero run).
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && (disp_bcd[i] == 4'h0);
    end

    // Per-digit pattern; digit 0 is never blanked, dp survives blanking.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        seven_seg_scan_driver_glyph u_glyph (
            .code  (disp_bcd[i]),
            .glyph (glyph[i])
        );
        if (i == 0) begin : g_lsd
            assign seg_d[i] = {~disp_dp[i], glyph[i]};
        end else begin : g_msd
            assign seg_d[i] = {~disp_dp[i],
                               (bus.blank_en && zero_above[i]) ? GLYPH_OFF[6:0] : glyph[i]};
        end
    end

    // Prescaler and scan counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            bus.scan_idx   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            cnt            <= tick ? '0 : cnt + 1'b1;
            bus.frame_done <= wrap;
            if (tick)
                bus.scan_idx <= wrap ? '0 : bus.scan_idx + 1'b1;
        end
    end

    // Double buffer: a load on the wrap cycle bypasses pending so it shows at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_bcd <= '0;
            pend_dp  <= '0;
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else begin
            if (bus.load) begin
                pend_bcd <= bus.bcd_in;
                pend_dp  <= bus.dp_in;
            end
            if (wrap) begin
                disp_bcd <= bus.load ? bus.bcd_in : pend_bcd;
                disp_dp  <= bus.load ? bus.dp_in  : pend_dp;
            end
        end
    end

    // Output registers. The prescaler doubles as guard timer: the first
    // GUARD_CYCLES counts of each step keep all anodes off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.seg_out  <= GLYPH_OFF;
            bus.digit_en <= '1;
        end else if (cnt < CNT_W'(GUARD_CYCLES)) begin
            bus.seg_out  <= GLYPH_OFF;
            bus.digit_en <= '1;
        end else begin
            bus.seg_out  <= seg_d[bus.scan_idx];
            bus.digit_en <= ~(NUM_DIGITS'(1) << bus.scan_idx);
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
//   Directed bench for seven_seg_scan_driver (4 digits, CLK_DIV=4, GUARD_CYCLES=1).
//   A cycle-level reference model derives every output from the edge count since
//   reset and the history of loads; a compare process checks it each cycle, and
//   directed tasks pin hand-computed glyphs.
module tb_seven_seg_scan_driver;
    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int GRD = 1;
    localparam int FR  = ND * DIV;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (DIV),
        .GUARD_CYCLES (GRD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] glyph_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hD8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
`ifdef HEX_DIGITS_EN
            4'hA: return 8'h88;  4'hB: return 8'h83;  4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  4'hF: return 8'h8E;
`endif
            default: return 8'hFF;
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int e; logic [15:0] v; logic [3:0] dp; } load_t;
    load_t       hist[$];
    int          k = 0;
    bit          mvalid = 0;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_en;
    logic [1:0]  exp_idx;
    logic        exp_fd;

    initial begin
        int kk, s, p, d, f;
        logic [15:0] disp;
        logic [3:0]  dpv;
        logic [3:0]  nib;
        logic [7:0]  g;
        bit          blank;
        forever begin
            @(posedge clk);
            if (reset) begin
                k = 0;
                hist.delete();
                exp_seg = 8'hFF; exp_en = 4'hF; exp_idx = 2'd0; exp_fd = 1'b0;
            end else begin
                k++;
                if (bus.load) hist.push_back('{k, bus.bcd_in, bus.dp_in});
                kk = k - 1;               // outputs reflect state before this edge
                s  = kk / DIV;
                p  = kk % DIV;
                d  = s % ND;
                f  = kk / FR;
                disp = 16'h0; dpv = 4'h0;
                foreach (hist[j])
                    if (hist[j].e <= FR * f) begin disp = hist[j].v; dpv = hist[j].dp; end
                if (p < GRD) begin
                    exp_seg = 8'hFF; exp_en = 4'hF;
                end else begin
                    exp_en = ~(4'b0001 << d);
                    nib    = 4'((disp >> (4 * d)) & 16'hF);
                    blank  = bus.blank_en && (d > 0) && ((disp >> (4 * d)) == 16'h0);
                    g      = glyph_of(nib);
                    exp_seg = {~dpv[d], blank ? 7'h7F : g[6:0]};
                end
                exp_idx = 2'((k / DIV) % ND);
                exp_fd  = (k % FR == 0);
            end
            mvalid = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                n_chk++;
                if (bus.seg_out !== exp_seg || bus.digit_en !== exp_en ||
                    bus.scan_idx !== exp_idx || bus.frame_done !== exp_fd) begin
                    n_fail++;
                    $display("FAIL cycle_model k=%0d seg=%h/%h en=%h/%h idx=%0d/%0d fd=%b/%b (got/exp)",
                             k, bus.seg_out, exp_seg, bus.digit_en, exp_en,
                             bus.scan_idx, exp_idx, bus.frame_done, exp_fd);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, got, want);
        end
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
        @(negedge clk);
        bus.bcd_in = v; bus.dp_in = dp; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        bit found = 0;
        for (int c = 0; c < 3 * FR && !found; c++) begin
            @(negedge clk);
            if (bus.frame_done) found = 1;
        end
        if (!found) begin
            n_chk++; n_fail++;
            $display("FAIL %s frame_done timeout got=0 expected=1", nm);
        end
    endtask

    task automatic check_digit(input int i, input logic [7:0] want, input string nm);
        logic [3:0] tgt;
        bit found = 0;
        tgt = ~(4'b0001 << i);
        for (int c = 0; c < 3 * FR && !found; c++) begin
            @(negedge clk);
            if (bus.digit_en == tgt) begin
                found = 1;
                check8(nm, bus.seg_out, want);
            end
        end
        if (!found) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout digit %0d never lit expected=%h", nm, i, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int fd_cnt, off_cnt;
        logic [3:0] first_en;
        reset = 1'b1;
        bus.bcd_in = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank_en = 1'b1;
        repeat (3) @(negedge clk);
        check8("reset_seg", bus.seg_out, 8'hFF);
        check8("reset_en", {4'h0, bus.digit_en}, 8'h0F);
        reset = 1'b0;

        // blanking of 0042
        load_word(16'h0042, 4'h0);
        wait_frame("f_0042");
        check_digit(0, 8'hA4, "b42_d0");
        check_digit(1, 8'h99, "b42_d1");
        check_digit(2, 8'hFF, "b42_d2");
        check_digit(3, 8'hFF, "b42_d3");
        // blank_en is live
        bus.blank_en = 1'b0;
        check_digit(2, 8'hC0, "nb42_d2");
        check_digit(3, 8'hC0, "nb42_d3");
        bus.blank_en = 1'b1;

        // zero value shows a single '0'
        load_word(16'h0000, 4'h0);
        wait_frame("f_0000");
        check_digit(0, 8'hC0, "z_d0");
        check_digit(1, 8'hFF, "z_d1");
        check_digit(2, 8'hFF, "z_d2");
        check_digit(3, 8'hFF, "z_d3");

        // embedded zero is not a leading zero
        load_word(16'h0402, 4'h0);
        wait_frame("f_0402");
        check_digit(0, 8'hA4, "e_d0");
        check_digit(1, 8'hC0, "e_d1");
        check_digit(2, 8'h99, "e_d2");
        check_digit(3, 8'hFF, "e_d3");

        // guard / one-hot / frame rate over 4 frames
        fd_cnt = 0; off_cnt = 0;
        for (int c = 0; c < 4 * FR; c++) begin
            @(negedge clk);
            if (bus.frame_done) fd_cnt++;
            if (bus.digit_en == 4'hF) off_cnt++;
        end
        check8("frame_done_count", 8'(fd_cnt), 8'd4);
        check8("guard_count", 8'(off_cnt), 8'(4 * ND * GRD));

        // mid-frame load is held until wrap
        wait_frame("f_mid");
        repeat (4) @(negedge clk);
        load_word(16'h1234, 4'h0);
        check_digit(3, 8'hFF, "mid_old_d3");
        wait_frame("f_1234");
        check_digit(0, 8'h99, "new_d0");
        check_digit(3, 8'hF9, "new_d3");

        // load on the wrap cycle appears in that same frame
        wait_frame("f_prewrap");
        repeat (FR - 2) @(negedge clk);
        load_word(16'h5678, 4'b0100);
        check_digit(0, 8'h80, "wrap_d0");
        check_digit(2, 8'h02, "wrap_d2_dp");
        check_digit(3, 8'h92, "wrap_d3");

        // hex code with dp on digit 0
        load_word(16'h000A, 4'b0001);
        wait_frame("f_hex");
`ifdef HEX_DIGITS_EN
        check_digit(0, 8'h08, "hex_d0");
`else
        check_digit(0, 8'h7F, "hex_d0");
`endif
        check_digit(1, 8'hFF, "hex_d1");

        // asynchronous reset mid-scan
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check8("areset_seg", bus.seg_out, 8'hFF);
        check8("areset_en", {4'h0, bus.digit_en}, 8'h0F);
        check8("areset_idx", {6'h0, bus.scan_idx}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        first_en = 4'hF;
        for (int c = 0; c < 2 * DIV && first_en == 4'hF; c++) begin
            @(negedge clk);
            first_en = bus.digit_en;
        end
        check8("first_digit_en", {4'h0, first_en}, 8'h0E);
        check8("first_digit_seg", bus.seg_out, 8'hC0);

        repeat (FR) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
